multiword_add_seq: RTL
======================

Name: multiword_add_seq

Overview:
- Multi-cycle add/subtract sequencer for operands wider than the adder datapath.
- Splits each TOTAL-bit operand (TOTAL = WIDTH*CHUNKS) into CHUNKS slices and runs them LSB-first through a single shared WIDTH-bit carry-lookahead adder, one slice per cycle.
- Chains the carry between slices through a register.
- Sits between the ALU issue logic (valid/ready request) and the writeback stage (valid/ready response), so wide arithmetic is possible without a TOTAL-bit adder.

Parameters:
- WIDTH, 8: bits per slice; width of the shared CLA instance.
- CHUNKS, 4: number of slices per operation; must be >= 2.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start_valid  input  1  request present
- start_ready  output  1  block can accept a request
- registerA  input  WIDTH*CHUNKS  operand A
- registerB  input  WIDTH*CHUNKS  operand B
- sub  input  1  1 = A-B, 0 = A+B+carryIn
- carryIn  input  1  carry seed for add; ignored when sub=1
- flush  input  1  synchronous abort
- result  output  WIDTH*CHUNKS  sum/difference
- carry_out  output  1  carry out of the MSB slice; for sub, 1 = no borrow
- overflow  output  1  signed two's-complement overflow
- done_valid  output  1  result valid
- done_ready  input  1  consumer accepts result

Behaviour:
- Clock and reset: one clock domain (clk). reset_n is asynchronous, active-low.
- Reset values, while reset_n=0: state=IDLE; slice counter=0; carry register=0; result=0; carry_out=0; overflow=0; done_valid=0; start_ready=0. start_ready rises on the first clock edge after reset release.
- States: IDLE, RUN, DONE.
- start_ready = (state==IDLE).
- done_valid = (state==DONE).
- IDLE:
  - On start_valid && start_ready at edge E0, capture registerA into opA.
  - Capture Beff = sub ? ~registerB : registerB.
  - Carry register <= sub ? 1 : carryIn.
  - Counter <= 0; go to RUN.
- RUN, counter k:
  - CLA inputs are opA[k*WIDTH +: WIDTH], Beff slice k, and the carry register.
  - At each edge: result slice k <= CLA sum; carry register <= CLA carry out; counter++.
  - Results are written slice-by-slice in place. Untouched slices keep their previous values during RUN; consumers only sample in DONE.
  - Slice CHUNKS-1 is written at edge E_CHUNKS. At the same edge:
    - carry_out <= CLA carry out.
    - overflow <= (opA MSB == Beff MSB) && (sum MSB != opA MSB).
    - state <= DONE.
- Latency: done_valid is high exactly CHUNKS cycles after the accept edge. Throughput is one operation per CHUNKS+2 cycles minimum.
- DONE:
  - result, carry_out and overflow are held stable.
  - On done_ready at an edge, go to IDLE. done_valid drops and start_ready rises the next cycle.
  - No request is accepted in the same cycle as the done handshake.
- flush:
  - In RUN or DONE: state <= IDLE at the next edge; done_valid is never asserted for the aborted operation.
  - In IDLE: ignored; flush has priority over start_valid, so no accept occurs that cycle.
  - result, carry_out and overflow keep stale values after flush.
- start_valid outside IDLE is ignored. Operand inputs are sampled only at the accept edge.
- sub=1 with carryIn=1: carryIn is ignored; the result is exactly A-B.
- Wrap-around: all arithmetic is modulo 2^TOTAL; there is no saturation.
- reset_n asserted mid-RUN or in DONE: immediate return to reset values; the operation is lost.

Decomposition:
- Shared package holds:
  - state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - counter width localparam CNT_W = $clog2(CHUNKS).
- TOTAL is a localparam inside the block.
- One sub-module: the team's existing WIDTH-bit carry-lookahead adder, CLA, instantiated once with WIDTH passed through.
- FSM, slice muxing and result registers stay in this block.

Test Plan (WIDTH=8, CHUNKS=4):
1. A=0x000000FF, B=0x00000001, sub=0, carryIn=0 -> result=0x00000100, carry_out=0, overflow=0; done_valid high exactly 4 cycles after accept.
2. A=0xFFFFFFFF, B=0x00000001, sub=0, carryIn=0 -> result=0x00000000, carry_out=1, overflow=0; the carry ripples through all 4 slices.
3. A=0x00000005, B=0x00000007, sub=1, carryIn=1 -> result=0xFFFFFFFE, carry_out=0 (borrow), overflow=0.
4. A=0x7FFFFFFF, B=0x00000001, sub=0 -> result=0x80000000, overflow=1, carry_out=0. Also A=0x80000000, B=0x00000001, sub=1 -> result=0x7FFFFFFF, overflow=1, carry_out=1.
5. Hold done_ready=0 for 3 cycles after done_valid, and pulse start_valid during RUN and DONE -> result stays constant and start_ready=0 throughout. The pulses are not accepted. After done_ready=1: IDLE next cycle, with a new accept possible one cycle later.
6. Two abort cases:
   - flush during RUN with counter=2 -> IDLE next edge; done_valid never rises; the next request completes correctly.
   - reset_n=0 asynchronously mid-RUN -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/multiword_add_seq_pkg.sv
// Shared definitions for the multi-word add/subtract sequencer.
package multiword_add_seq_pkg;

  // Default build: four 8-bit slices, giving a 32-bit operation.
  localparam int DEF_WIDTH  = 8;
  localparam int DEF_CHUNKS = 4;

  // Bits needed to index a slice 0..chunks-1 (at least one bit).
  function automatic int cnt_w_for(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

  // Slice counter width for the default build.
  localparam int CNT_W = $clog2(DEF_CHUNKS);

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multiword_add_seq_cla.sv
// WIDTH-bit carry-lookahead adder: every carry is a flat sum of
// generate/propagate products, so no carry ripples through the slice.
module multiword_add_seq_cla #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic             term;
  logic             prop;

  assign g = a & b;
  assign p = a ^ b;

  // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin.
  always_comb begin
    // NOTE: every variable gets a value before any branch or loop so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    c    = '0;
    term = 1'b0;
    prop = 1'b0;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      // NOTE: combinational blocks use blocking '=' so term/prop accumulate
      // in order within one evaluation; registers elsewhere use '<='.
      term = g[i];
      prop = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i+1] = term | (prop & cin);
    end
  end

  assign sum  = p ^ c[WIDTH-1:0];
  assign cout = c[WIDTH];

endmodule

// File: rtl/multiword_add_seq.sv
// Multi-cycle add/subtract of WIDTH*CHUNKS-bit operands through one shared
// WIDTH-bit CLA, one slice per cycle LSB-first, carry chained in a register.
module multiword_add_seq
  import multiword_add_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CHUNKS = DEF_CHUNKS
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [WIDTH*CHUNKS-1:0] registerA,
  input  logic [WIDTH*CHUNKS-1:0] registerB,
  input  logic                    sub,
  input  logic                    carryIn,
  input  logic                    flush,
  output logic [WIDTH*CHUNKS-1:0] result,
  output logic                    carry_out,
  output logic                    overflow,
  output logic                    done_valid,
  input  logic                    done_ready
);

  localparam int TOTAL = WIDTH * CHUNKS;
  // Counter is never narrower than the package default; widens for more slices.
  localparam int CW = (cnt_w_for(CHUNKS) > CNT_W) ? cnt_w_for(CHUNKS) : CNT_W;
  localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

  state_t           state_q;
  state_t           state_d;
  logic             alive_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [TOTAL-1:0] opa_q;
  logic [TOTAL-1:0] beff_q;
  logic [TOTAL-1:0] result_q;
  logic             carry_out_q;
  logic             overflow_q;
  logic [WIDTH-1:0] slice_a;
  logic [WIDTH-1:0] slice_b;
  logic [WIDTH-1:0] slice_sum;
  logic             slice_cout;
  logic             accept;
  logic             last;

  // alive_q holds start_ready low until the first edge after reset release.
  assign start_ready = alive_q && (state_q == IDLE);
  assign done_valid  = (state_q == DONE);
  // flush outranks a request in IDLE.
  assign accept      = start_valid && start_ready && !flush;
  assign last        = (cnt_q == LAST);

  assign slice_a = opa_q[cnt_q*WIDTH +: WIDTH];
  assign slice_b = beff_q[cnt_q*WIDTH +: WIDTH];

  multiword_add_seq_cla #(
    .WIDTH (WIDTH)
  ) u_cla (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: registers take '<=' so every flop samples pre-edge values and
      // simulation matches the synthesized hardware regardless of block order.
      state_q <= state_d;
    end
  end

  // Next state: accept, walk the slices, hold the result, abort on flush.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (flush) state_d = IDLE;
               else if (last) state_d = DONE;
      DONE:    if (flush || done_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, then write one result slice per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the operand registers are reset too; they are a few flops, not
      // a memory array, so a reset costs little and keeps the CLA inputs known.
      alive_q     <= 1'b0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      opa_q       <= '0;
      beff_q      <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      if (accept) begin
        opa_q   <= registerA;
        beff_q  <= sub ? ~registerB : registerB;
        carry_q <= sub | carryIn;
        cnt_q   <= '0;
      end else if ((state_q == RUN) && !flush) begin
        result_q[cnt_q*WIDTH +: WIDTH] <= slice_sum;
        carry_q                        <= slice_cout;
        cnt_q                          <= cnt_q + 1'b1;
        if (last) begin
          carry_out_q <= slice_cout;
          overflow_q  <= (opa_q[TOTAL-1] == beff_q[TOTAL-1]) &&
                         (slice_sum[WIDTH-1] != opa_q[TOTAL-1]);
        end
      end
    end
  end

  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule
